// File: rtl/trigger_ctrl_if.sv
// Command bus from the SUMP command decoder into the trigger sequencer.
// The decoder drives the opcode, payload and a one-cycle execute strobe.
interface trigger_ctrl_if;
  logic [7:0]  opc_i;
  logic [31:0] data_i;
  logic        exec_i;

  modport master (
    output opc_i,
    output data_i,
    output exec_i
  );

  modport slave (
    input opc_i,
    input data_i,
    input exec_i
  );
endinterface

// File: rtl/trigger_ctrl.sv
// Trigger-stage sequencer: decodes trigger commands into per-stage write strobes,
// arms the stages together, tracks the shared level and latches a sticky run flag.
module trigger_ctrl #(
  parameter int NUM_STAGES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_in,
  trigger_ctrl_if.slave         cmd,
  input  logic                  stb_i,
  output logic [31:0]           stg_cmd_o,
  output logic [NUM_STAGES-1:0] stg_set_mask_o,
  output logic [NUM_STAGES-1:0] stg_set_val_o,
  output logic [NUM_STAGES-1:0] stg_set_cfg_o,
  output logic                  stg_arm_o,
  output logic                  stg_stb_o,
  output logic [1:0]            stg_lvl_o,
  input  logic [NUM_STAGES-1:0] stg_match_i,
  input  logic [NUM_STAGES-1:0] stg_run_i,
  output logic                  armed_o,
  output logic                  run_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  localparam logic [7:0] OPC_RESET = 8'h00;
  localparam logic [7:0] OPC_ARM   = 8'h01;

  state_t                  state;
  logic                    is_soft_reset;
  logic                    is_arm;
  logic                    is_cfg;
  logic                    cfg_accept;
  logic [1:0]              cfg_kind;
  logic [NUM_STAGES-1:0]   cfg_sel;
  logic [NUM_STAGES-1:0]   mask_stb;
  logic [NUM_STAGES-1:0]   val_stb;
  logic [NUM_STAGES-1:0]   cfg_stb;

  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [1:0] idx);
    logic [NUM_STAGES-1:0] one;
    one = {{(NUM_STAGES-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // Command decode; stage writes are only honoured outside ARMED.
  always_comb begin
    is_soft_reset = 1'b0;
    is_arm        = 1'b0;
    is_cfg        = 1'b0;
    cfg_accept    = 1'b0;
    cfg_kind      = cmd.opc_i[1:0];
    cfg_sel       = stage_onehot(cmd.opc_i[3:2]);
    mask_stb      = {NUM_STAGES{1'b0}};
    val_stb       = {NUM_STAGES{1'b0}};
    cfg_stb       = {NUM_STAGES{1'b0}};
    if (cmd.exec_i) begin
      is_soft_reset = (cmd.opc_i == OPC_RESET);
      is_arm        = (cmd.opc_i == OPC_ARM);
      is_cfg        = (cmd.opc_i[7:4] == 4'hC);
    end else begin
      is_soft_reset = 1'b0;
    end
    if (is_cfg && (state != ARMED)) begin
      case (cfg_kind)
        2'd0: begin
          mask_stb   = cfg_sel;
          cfg_accept = 1'b1;
        end
        2'd1: begin
          val_stb    = cfg_sel;
          cfg_accept = 1'b1;
        end
        2'd2: begin
          cfg_stb    = cfg_sel;
          cfg_accept = 1'b1;
        end
        default: cfg_accept = 1'b0;
      endcase
    end else begin
      cfg_accept = 1'b0;
    end
  end

  // Sequencer FSM with registered strobes, level and run flag.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      stg_cmd_o      <= 32'h0000_0000;
      stg_set_mask_o <= {NUM_STAGES{1'b0}};
      stg_set_val_o  <= {NUM_STAGES{1'b0}};
      stg_set_cfg_o  <= {NUM_STAGES{1'b0}};
      stg_arm_o      <= 1'b0;
      stg_lvl_o      <= 2'd0;
      armed_o        <= 1'b0;
      run_o          <= 1'b0;
    end else begin
      stg_set_mask_o <= mask_stb;
      stg_set_val_o  <= val_stb;
      stg_set_cfg_o  <= cfg_stb;
      stg_arm_o      <= 1'b0;
      if (cfg_accept) begin
        stg_cmd_o <= cmd.data_i;
      end
      if (is_soft_reset) begin
        state     <= IDLE;
        armed_o   <= 1'b0;
        stg_lvl_o <= 2'd0;
        run_o     <= 1'b0;
      end else if (is_arm && (state != ARMED)) begin
        state     <= ARMED;
        armed_o   <= 1'b1;
        stg_arm_o <= 1'b1;
        stg_lvl_o <= 2'd0;
        run_o     <= 1'b0;
      end else begin
        case (state)
          ARMED: begin
            // Run wins over match: the level freezes at the firing edge.
            if (|stg_run_i) begin
              state   <= FIRED;
              armed_o <= 1'b0;
              run_o   <= 1'b1;
            end else if ((|stg_match_i) && (stg_lvl_o != 2'd3)) begin
              stg_lvl_o <= stg_lvl_o + 2'd1;
            end
          end
          IDLE:    state <= IDLE;
          FIRED:   state <= FIRED;
          default: begin
            state   <= IDLE;
            armed_o <= 1'b0;
          end
        endcase
      end
    end
  end

  assign stg_stb_o = stb_i & (state == ARMED);

endmodule

// File: doc/trigger_ctrl.md
# trigger_ctrl

Sequencer for the trigger-stage array of the logic analyzer core. It decodes trigger-related SUMP commands into per-stage configuration strobes and arms all stages together. It gates the sample strobe into the stages and tracks the shared trigger level. It collapses the per-stage run outputs into a single sticky run flag for the capture controller. It sits between the command decoder and the `NUM_STAGES` trigger-stage instances.

## Interface
- `NUM_STAGES`, 4: number of trigger stages; fixed at 4 for SUMP compatibility (opcode bits [3:2] select the stage).
- `clk_i` input 1: system clock; all state on rising edge.
- `rst_in` input 1: asynchronous, active-low reset.
- `opc_i` input 8: command opcode from the decoder.
- `data_i` input 32: command payload.
- `exec_i` input 1: one-cycle strobe; `opc_i` and `data_i` are valid.
- `stb_i` input 1: sample strobe from the sampler.
- `stg_cmd_o` output 32: registered payload broadcast to all stages.
- `stg_set_mask_o` output NUM_STAGES: one-hot per-stage mask write strobe.
- `stg_set_val_o` output NUM_STAGES: one-hot per-stage value write strobe.
- `stg_set_cfg_o` output NUM_STAGES: one-hot per-stage config write strobe.
- `stg_arm_o` output 1: one-cycle arm pulse to all stages.
- `stg_stb_o` output 1: gated sample strobe to all stages.
- `stg_lvl_o` output 2: current trigger level to all stages.
- `stg_match_i` input NUM_STAGES: per-stage match.
- `stg_run_i` input NUM_STAGES: per-stage run request.
- `armed_o` output 1: high in state ARMED.
- `run_o` output 1: sticky capture-start flag.

## Operation
- FSM states:
  - IDLE: reset state.
  - ARMED.
  - FIRED.
- Opcode decode is evaluated only when `exec_i`=1:
  - 0x00 (soft reset): from any state go to IDLE. Clear `stg_lvl_o` and `run_o`. Stage configuration is not touched.
  - 0x01 (arm): IDLE or FIRED → ARMED. Pulse `stg_arm_o`, clear `stg_lvl_o` to 0, clear `run_o`. Ignored in ARMED (no pulse).
  - 0xC0–0xCF: stage index = `opc_i[3:2]`, kind = `opc_i[1:0]`.
    - Kind 0 pulses `stg_set_mask_o`, 1 pulses `stg_set_val_o`, 2 pulses `stg_set_cfg_o`, in each case only the bit of the selected stage. `stg_cmd_o` is loaded with `data_i`.
    - Kind 3 is ignored.
    - Writes are accepted in IDLE and FIRED. In ARMED they are dropped: no strobe, and `stg_cmd_o` is unchanged.
  - All other opcodes are ignored.
- `stg_stb_o` = `stb_i` while in ARMED, 0 otherwise (combinational).
- Level:
  - In ARMED, if any `stg_match_i` bit is set and no `stg_run_i` bit is set, `stg_lvl_o` increments by 1.
  - At most one increment per cycle, regardless of how many stages match.
  - Saturates at 3; no wrap.
- Fire: in ARMED, any `stg_run_i` bit set → FIRED, `run_o`=1.
  - Run has priority over match in the same cycle; the level is frozen.
- In IDLE and FIRED, `stg_match_i` and `stg_run_i` are ignored.
- `run_o` stays high in FIRED until a soft reset or re-arm.

## Timing
- Reset values: state IDLE, and every output at 0: `stg_cmd_o`, all `stg_set_*_o`, `stg_arm_o`, `stg_lvl_o`, `armed_o`, `run_o`. `stg_stb_o` is 0 because the state is IDLE.
- Command latency: `exec_i` sampled at edge n → strobes, `stg_cmd_o`, and `stg_arm_o` valid for exactly the cycle after edge n. `armed_o` rises at edge n.
- Strobes and `stg_arm_o` are single-cycle pulses. Back-to-back `exec_i` gives back-to-back pulses with the payload updated every cycle.
- `stg_lvl_o` updates at the edge that samples the match. Stages see the new level from the next cycle.
- `run_o` and the FIRED transition occur at the edge sampling `stg_run_i`. `stg_stb_o` drops in the same cycle.
- Arm and soft reset take effect at the `exec_i` edge and override a same-cycle match or run.
- `rst_in` low at any time, including mid-command, clears everything asynchronously. No pending strobe is emitted after release.

## Test plan
- Reset: drive `rst_in`=0 mid-way through an ARMED sequence with `stb_i`=1 → all outputs 0 immediately; after release, state is IDLE and `stg_stb_o`=0.
- Config decode:
  - exec 0xC5 with data 0xDEADBEEF → one cycle later `stg_set_val_o`=4'b0010 and `stg_cmd_o`=0xDEADBEEF; all other strobes 0.
  - exec 0xCB → no strobe.
- Arm and gating: exec 0x01 → `stg_arm_o` pulses for 1 cycle, `armed_o`=1, `stg_stb_o` follows `stb_i`.
  - A second 0x01 → no pulse.
  - A 0xC0 write while ARMED → no strobe.
- Level: in ARMED, `stg_match_i`=4'b0011 for one cycle → `stg_lvl_o`=1 (a single increment).
  - Four more single-cycle matches → level saturates at 3.
- Fire priority: `stg_match_i`=4'b0001 and `stg_run_i`=4'b0100 in the same cycle at level 1 → `run_o`=1, FIRED, `stg_lvl_o` stays 1, `stg_stb_o`=0.
  - Then exec 0x00 → `run_o`=0, IDLE, `stg_lvl_o`=0.
- Re-arm from FIRED: exec 0x01 → `run_o` clears, `stg_lvl_o`=0, `stg_arm_o` pulses, ARMED.
